// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory with self-clear, program port and registered fetch
module instr_mem_sync #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter int                ADDR_W    = 32,
    parameter bit                BYTE_ADDR = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, next_state;
    logic [IDX_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] fidx, pidx;
    logic fbad, pbad, pwe_ok, fetch_go;
    assign fidx = BYTE_ADDR ? fetch_addr >> 2 : fetch_addr;
    assign pidx = BYTE_ADDR ? prog_addr >> 2 : prog_addr;
    // range check uses the full index so high addresses never alias into the array
    assign fbad = (BYTE_ADDR && fetch_addr[1:0] != 2'b00) || fidx >= ADDR_W'(DEPTH);
    assign pbad = (BYTE_ADDR && prog_addr[1:0] != 2'b00) || pidx >= ADDR_W'(DEPTH);
    assign busy = state == CLEAR;
    assign pwe_ok = prog_we && !busy && !pbad;
    assign fetch_go = fetch_req && !busy;
    always_comb begin
        next_state = (state == CLEAR && clr_idx == IDX_W'(DEPTH - 1)) ? READY : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= next_state;
            clr_idx <= busy ? clr_idx + IDX_W'(1) : clr_idx;
        end
    end
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_idx] <= NOP_WORD;
        else if (pwe_ok)
            mem[pidx[IDX_W-1:0]] <= prog_data;
    end
    // read-first: the fetch samples the array before a same-edge program write lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            prog_err    <= 1'b0;
        end else begin
            prog_err <= prog_we && (busy || pbad);
            if (!stall) begin
                instr_valid <= fetch_go;
                if (fetch_go) begin
                    instr       <= fbad ? NOP_WORD : mem[fidx[IDX_W-1:0]];
                    fetch_fault <= fbad;
                end
            end
        end
    end
endmodule
